// File: rtl/demux_1x3_seq.sv
// demux_1x3_seq: registered 1-to-3 demultiplexer that distributes one result
// stream into three lane holding registers. It has a valid/ready handshake
// and an optional auto-sequencing mode that fills lanes 0, 1 and 2 in order.
//
// Optional feature (macro DEMUX_PARITY_EN): adds a PAR[2:0] output. Each time
// a lane is written, its parity bit is set to the XOR reduction of the word.
//
// Handshake: a word on D_in transfers on a rising edge when IN_VALID and
// IN_READY are both high. IN_READY is combinational from AUTO, MS, VALID and
// ACK, and it never depends on IN_VALID. ACK[k] consumes lane k. If the lane
// is freed in the same cycle, a new word may land in it on that same edge.
module demux_1x3_seq #(
  parameter int P = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         AUTO,
  input  logic [1:0]   MS,
  input  logic [P-1:0] D_in,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [2:0]   ACK,
  output logic [P-1:0] D_0,
  output logic [P-1:0] D_1,
  output logic [P-1:0] D_2,
  output logic [2:0]   VALID,
  output logic         FRAME_DONE,
  output logic         SEL_ERR,
  output logic [1:0]   dbg_state
`ifdef DEMUX_PARITY_EN
  ,
  output logic [2:0]   PAR
`endif
);

  // Auto sequencer states. The encoding doubles as the lane pointer.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_L1   = 2'd1,
    S_L2   = 2'd2
  } state_t;

  state_t       state;
  logic [1:0]   tgt;        // target lane for this cycle
  logic         sel_bad;    // manual mode with the illegal select 2'b11
  logic         lane_ready; // target lane can take a word
  logic         accept;     // handshake completes on this edge
  logic [2:0]   wr;         // one-hot lane write enables
  logic [P-1:0] lane_d [3];
  logic [2:0]   lane_v;

  assign dbg_state = state;

  // Target lane selection, ready generation and lane write decode.
  always_comb begin
    tgt        = AUTO ? state : MS;
    sel_bad    = ~AUTO & (MS == 2'b11);
    lane_ready = 1'b0;
    case (tgt)
      2'd0:    lane_ready = ~lane_v[0] | ACK[0];
      2'd1:    lane_ready = ~lane_v[1] | ACK[1];
      2'd2:    lane_ready = ~lane_v[2] | ACK[2];
      default: lane_ready = 1'b0;
    endcase
    // An illegal manual select always accepts, so the word is dropped
    // instead of stalling the upstream stage.
    IN_READY = sel_bad | lane_ready;
    accept   = IN_VALID & IN_READY;
    wr       = 3'b000;
    if (accept && !sel_bad) begin
      wr = 3'b001 << tgt;
    end
  end

  // Lane holding registers. A write has priority over an ACK clear, so a
  // lane that is consumed and refilled on the same edge stays valid.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int k = 0; k < 3; k++) begin
        lane_d[k] <= '0;
      end
      lane_v <= 3'b000;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (wr[k]) begin
          lane_d[k] <= D_in;
          lane_v[k] <= 1'b1;
        end else if (ACK[k]) begin
          lane_v[k] <= 1'b0;
        end
      end
    end
  end

  assign D_0   = lane_d[0];
  assign D_1   = lane_d[1];
  assign D_2   = lane_d[2];
  assign VALID = lane_v;

  // Auto sequencer and its registered FRAME_DONE pulse. Leaving auto mode
  // drops any partial frame, so the next auto word starts at lane 0.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= S_IDLE;
      FRAME_DONE <= 1'b0;
    end else begin
      FRAME_DONE <= 1'b0;
      if (!AUTO) begin
        state <= S_IDLE;
      end else if (accept) begin
        case (state)
          S_IDLE:  state <= S_L1;
          S_L1:    state <= S_L2;
          S_L2: begin
            state      <= S_IDLE;
            FRAME_DONE <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Registered one-cycle pulse flagging a discarded word (manual MS = 2'b11).
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      SEL_ERR <= 1'b0;
    end else begin
      SEL_ERR <= accept & sel_bad;
    end
  end

`ifdef DEMUX_PARITY_EN
  // Per-lane parity, captured together with the lane data.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      PAR <= 3'b000;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (wr[k]) begin
          PAR[k] <= ^D_in;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_demux_1x3_seq.sv
// tb_demux_1x3_seq: directed test-plan steps, then randomized traffic. Every
// cycle is checked against a lane-level reference model of the demultiplexer.
module tb_demux_1x3_seq;

  logic        CLK;
  logic        RST;
  logic        AUTO;
  logic [1:0]  MS;
  logic [31:0] D_in;
  logic        IN_VALID;
  logic        IN_READY;
  logic [2:0]  ACK;
  logic [31:0] D_0, D_1, D_2;
  logic [2:0]  VALID;
  logic        FRAME_DONE;
  logic        SEL_ERR;
  logic [1:0]  dbg_state;
`ifdef DEMUX_PARITY_EN
  logic [2:0]  PAR;
`endif

  int checks   = 0;
  int failures = 0;

  // reference model: lane words, lane full flags, frame position 0..2
  logic [31:0] m_d [3];
  logic [2:0]  m_v;
  int          m_pos;
  logic        m_fd;
  logic        m_se;
  logic [2:0]  m_p;

  logic [31:0] exp_q[$];

  demux_1x3_seq #(.P(32)) dut (
    .CLK(CLK), .RST(RST), .AUTO(AUTO), .MS(MS), .D_in(D_in),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .ACK(ACK),
    .D_0(D_0), .D_1(D_1), .D_2(D_2), .VALID(VALID),
    .FRAME_DONE(FRAME_DONE), .SEL_ERR(SEL_ERR), .dbg_state(dbg_state)
`ifdef DEMUX_PARITY_EN
    , .PAR(PAR)
`endif
  );

  // clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) m_d[k] = 32'h0;
    m_v   = 3'b000;
    m_pos = 0;
    m_fd  = 1'b0;
    m_se  = 1'b0;
    m_p   = 3'b000;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ":D_0"}, D_0, m_d[0]);
    chk({tag, ":D_1"}, D_1, m_d[1]);
    chk({tag, ":D_2"}, D_2, m_d[2]);
    chk({tag, ":VALID"}, {29'd0, VALID}, {29'd0, m_v});
    chk({tag, ":FRAME_DONE"}, {31'd0, FRAME_DONE}, {31'd0, m_fd});
    chk({tag, ":SEL_ERR"}, {31'd0, SEL_ERR}, {31'd0, m_se});
`ifdef DEMUX_PARITY_EN
    chk({tag, ":PAR"}, {29'd0, PAR}, {29'd0, m_p});
`endif
  endtask

  // driver: apply inputs after a falling edge, check ready, clock, check state
  task automatic step(input string tag, input logic a, input logic [1:0] ms,
                      input logic [31:0] din, input logic iv, input logic [2:0] ack);
    int  lane;
    bit  bad, rdy, acc;
    AUTO = a; MS = ms; D_in = din; IN_VALID = iv; ACK = ack;
    #1;
    lane = a ? m_pos : int'(ms);
    bad  = !a && (ms == 2'b11);
    rdy  = bad ? 1'b1 : (!m_v[lane] || ack[lane]);
    chk({tag, ":IN_READY"}, {31'd0, IN_READY}, {31'd0, rdy});
    acc  = iv && rdy;
    for (int k = 0; k < 3; k++) begin
      if (acc && !bad && lane == k) begin
        m_d[k] = din;
        m_v[k] = 1'b1;
        m_p[k] = ^din;
      end else if (ack[k]) begin
        m_v[k] = 1'b0;
      end
    end
    m_fd = a && acc && (m_pos == 2);
    m_se = acc && bad;
    if (!a) m_pos = 0;
    else if (acc) m_pos = (m_pos + 1) % 3;
    @(posedge CLK);
    #1;
    check_outputs(tag);
    @(negedge CLK);
  endtask

  // assert reset between edges and check outputs clear without a clock
  task automatic async_reset(input string tag);
    #2;
    RST = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    logic [31:0] w;
    RST = 1'b0; AUTO = 1'b0; MS = 2'd0; D_in = 32'h0; IN_VALID = 1'b0; ACK = 3'b000;
    model_reset();
    #1;
    check_outputs("reset");
    chk("reset:IN_READY", {31'd0, IN_READY}, 32'd1);
    @(negedge CLK);
    RST = 1'b1;

    // manual writes, one lane per cycle
    exp_q.push_back(32'h00000000);
    exp_q.push_back(32'h80000001);
    exp_q.push_back(32'hC0000003);
    step("man0", 1'b0, 2'd0, 32'h00000000, 1'b1, 3'b000);
    step("man1", 1'b0, 2'd1, 32'h80000001, 1'b1, 3'b000);
    step("man2", 1'b0, 2'd2, 32'hC0000003, 1'b1, 3'b000);
    w = exp_q.pop_front(); chk("man:D_0", D_0, w);
    w = exp_q.pop_front(); chk("man:D_1", D_1, w);
    w = exp_q.pop_front(); chk("man:D_2", D_2, w);
    chk("man:VALID", {29'd0, VALID}, 32'd7);

    // backpressure on a full lane, then consume and refill on the same edge
    step("bp_stall", 1'b0, 2'd1, 32'h12345678, 1'b1, 3'b000);
    chk("bp_stall:D_1", D_1, 32'h80000001);
    step("bp_ack", 1'b0, 2'd1, 32'h12345678, 1'b1, 3'b010);
    chk("bp_ack:D_1", D_1, 32'h12345678);
    chk("bp_ack:VALID1", {31'd0, VALID[1]}, 32'd1);

    // illegal select: word dropped, one SEL_ERR pulse
    step("illegal", 1'b0, 2'd3, 32'hDEADBEEF, 1'b1, 3'b000);
    step("illegal_after", 1'b0, 2'd3, 32'hDEADBEEF, 1'b0, 3'b000);

    // auto frame of three words, then a fourth that starts the next frame
    step("auto1", 1'b1, 2'd0, 32'd1, 1'b1, 3'b111);
    step("auto2", 1'b1, 2'd0, 32'd2, 1'b1, 3'b111);
    step("auto3", 1'b1, 2'd0, 32'd3, 1'b1, 3'b111);
    chk("auto3:FRAME_DONE", {31'd0, FRAME_DONE}, 32'd1);
    step("auto4", 1'b1, 2'd0, 32'd4, 1'b1, 3'b111);
    chk("auto4:D_0", D_0, 32'd4);
    chk("auto4:FRAME_DONE", {31'd0, FRAME_DONE}, 32'd0);

    // complete the frame, then abort the next one with reset after two words
    step("auto5", 1'b1, 2'd0, 32'd5, 1'b1, 3'b111);
    step("auto6", 1'b1, 2'd0, 32'd6, 1'b1, 3'b111);
    step("abort1", 1'b1, 2'd0, 32'hA1, 1'b1, 3'b111);
    step("abort2", 1'b1, 2'd0, 32'hA2, 1'b1, 3'b111);
    async_reset("abort_rst");
    step("abort_next", 1'b1, 2'd0, 32'hA3, 1'b1, 3'b000);
    chk("abort_next:D_0", D_0, 32'hA3);

    // drop AUTO after two words: no FRAME_DONE, next auto word goes to lane 0
    step("drop_a", 1'b1, 2'd0, 32'hB1, 1'b1, 3'b111);
    step("drop_b", 1'b1, 2'd0, 32'hB2, 1'b1, 3'b111);
    step("drop_man", 1'b0, 2'd0, 32'h0, 1'b0, 3'b111);
    step("drop_next", 1'b1, 2'd0, 32'hB3, 1'b1, 3'b111);
    chk("drop_next:D_0", D_0, 32'hB3);
    chk("drop_next:FRAME_DONE", {31'd0, FRAME_DONE}, 32'd0);

`ifdef DEMUX_PARITY_EN
    step("par_a", 1'b0, 2'd1, 32'h80000001, 1'b1, 3'b010);
    chk("par_a:PAR1", {31'd0, PAR[1]}, 32'd0);
    step("par_b", 1'b0, 2'd1, 32'hC0000003, 1'b1, 3'b010);
    chk("par_b:PAR1", {31'd0, PAR[1]}, 32'd0);
    step("par_c", 1'b0, 2'd1, 32'h00000001, 1'b1, 3'b010);
    chk("par_c:PAR1", {31'd0, PAR[1]}, 32'd1);
`endif

    // randomized traffic; AUTO held in blocks so frames complete
    for (int blk = 0; blk < 20; blk++) begin
      logic a;
      a = ($urandom_range(0, 2) != 0);
      for (int c = 0; c < 20; c++) begin
        step("rand", a, 2'($urandom_range(0, 3)), $urandom,
             1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
